// File: rtl/i2s_tx.sv
// I2S master transmitter: derives scki/bck/lrck from clk and shifts one held
// stereo sample per 64-bck frame onto dout, MSB first with a one-bck delay.
module i2s_tx #(
    parameter int unsigned BCK_DIV = 4,
    parameter int unsigned WIDTH   = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] left_in,
    input  logic [WIDTH-1:0] right_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             scki,
    output logic             bck,
    output logic             lrck,
    output logic             dout,
    output logic             underrun
);

    localparam int unsigned PW = $clog2(BCK_DIV);
    localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(BCK_DIV - 1);
    localparam logic [PW-1:0] P_HALF = PW'(BCK_DIV / 2);

    logic [PW-1:0]    p, p_n;
    logic [5:0]       k, k_n;
    logic [WIDTH-1:0] hold_l, hold_l_n, hold_r, hold_r_n;
    logic             hold_full, hold_full_n;
    logic [WIDTH-1:0] sh_l, sh_l_n, sh_r, sh_r_n;
    logic             scki_n, bck_n, lrck_n, dout_n, underrun_n, in_ready_n;

    logic             wrap, load;
    logic [4:0]       s_n;
    logic [5:0]       idx;
    logic [WIDTH-1:0] word_n;

    // Next-state and registered-output values.
    always_comb begin
        p_n         = p;
        k_n         = k;
        hold_l_n    = hold_l;
        hold_r_n    = hold_r;
        hold_full_n = hold_full;
        sh_l_n      = sh_l;
        sh_r_n      = sh_r;
        dout_n      = dout;
        underrun_n  = 1'b0;
        s_n         = 5'd0;
        idx         = 6'd0;
        word_n      = '0;

        wrap = (p == P_LAST);
        load = wrap && (k == 6'd63);

        p_n = wrap ? '0 : p + PW'(1);
        if (wrap) begin
            k_n = k + 6'd1;
        end

        // Frame boundary: take the held sample or send silence.
        if (load) begin
            if (hold_full) begin
                sh_l_n      = hold_l;
                sh_r_n      = hold_r;
                hold_full_n = 1'b0;
            end else begin
                sh_l_n     = '0;
                sh_r_n     = '0;
                underrun_n = 1'b1;
            end
        end

        // Accept uses the pre-load flag, so a same-clk accept waits a frame.
        if (in_valid && !hold_full) begin
            hold_l_n    = left_in;
            hold_r_n    = right_in;
            hold_full_n = 1'b1;
        end

        // Data bit for the slot position the counter is moving into.
        if (wrap) begin
            s_n    = k_n[4:0];
            word_n = k_n[5] ? sh_r_n : sh_l_n;
            idx    = 6'(WIDTH) - {1'b0, s_n};
            if ((s_n != 5'd0) && ({1'b0, s_n} <= 6'(WIDTH))) begin
                dout_n = word_n[idx[IW-1:0]];
            end else begin
                dout_n = 1'b0;
            end
        end

        scki_n     = ~scki;
        bck_n      = (p_n >= P_HALF);
        lrck_n     = k_n[5];
        in_ready_n = ~hold_full_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p         <= '0;
            k         <= '0;
            hold_l    <= '0;
            hold_r    <= '0;
            hold_full <= 1'b0;
            sh_l      <= '0;
            sh_r      <= '0;
            scki      <= 1'b0;
            bck       <= 1'b0;
            lrck      <= 1'b0;
            dout      <= 1'b0;
            underrun  <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            p         <= p_n;
            k         <= k_n;
            hold_l    <= hold_l_n;
            hold_r    <= hold_r_n;
            hold_full <= hold_full_n;
            sh_l      <= sh_l_n;
            sh_r      <= sh_r_n;
            scki      <= scki_n;
            bck       <= bck_n;
            lrck      <= lrck_n;
            dout      <= dout_n;
            underrun  <= underrun_n;
            in_ready  <= in_ready_n;
        end
    end

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- I2S master transmitter that drives an external stereo DAC from the system clock.
- Generates scki, bck and lrck, and serializes one stereo sample per frame onto dout.
- It is the output counterpart of the i2s receiver. It sits downstream of the inverse-FFT/synthesis path.
- A one-deep holding register with a valid/ready handshake decouples the producer from frame timing.

Parameters:
- BCK_DIV, 4: clk cycles per bck period. Must be even and ≥ 2.
- WIDTH, 24: audio sample width, two's complement. Must be ≤ 31. Each channel slot is fixed at 32 bck.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- left_in  in  WIDTH  left sample from producer.
- right_in  in  WIDTH  right sample from producer.
- in_valid  in  1  producer has a stereo sample on left_in/right_in.
- in_ready  out  1  holding register empty. Transfer occurs when in_valid && in_ready.
- scki  out  1  DAC system clock: clk/2, 50% duty.
- bck  out  1  bit clock: clk/BCK_DIV, 50% duty.
- lrck  out  1  word select. 0 = left slot, 1 = right slot. Period 64 bck.
- dout  out  1  serial data, MSB first, I2S format with 1-bck delay after an lrck edge.
- underrun  out  1  one-clk pulse when a frame starts with no sample held.

Behaviour:
- State registers:
  - phase counter p, range 0..BCK_DIV-1, increments every clk and wraps.
  - bit counter k, range 0..63, increments when p wraps.
  - holding register: hold_l, hold_r, plus hold_full flag.
  - shift words: sh_l, sh_r.
  - scki toggle flop.
- All outputs are registered. No combinational path from inputs to outputs.
- Output mapping:
  - bck = 1 when p ≥ BCK_DIV/2, so bck falls when p returns to 0.
  - lrck = k[5].
  - scki toggles every clk.
- dout per slot, with s = k mod 32 and word = sh_l when k < 32 else sh_r:
  - s in 1..WIDTH: dout = word[WIDTH - s].
  - s = 0 or s > WIDTH: dout = 0.
- Timing of changes: dout and lrck change only on the clk where p becomes 0, i.e. the bck falling edge. The DAC samples on bck rising edges.
- Frame load: on the clk where p wraps and k wraps 63 → 0:
  - If hold_full: sh_l/sh_r load from hold_l/hold_r, and hold_full clears.
  - If not hold_full: sh_l/sh_r load 0, and underrun = 1 for that one clk.
- Handshake:
  - in_ready = !hold_full.
  - When in_valid && in_ready, capture the inputs and set hold_full.
  - Producer must hold data stable while in_valid && !in_ready.
- Same-cycle accept and frame load: in_ready was 1, so the frame loads zeros and flags underrun. The accepted sample is held for the next frame. There is no bypass path.
- Latency: a sample accepted during frame n is output in frame n+1.
  - Left MSB appears on dout at k = 1 of frame n+1.
  - Right MSB appears at k = 33.
- Reset values:
  - p = 0, k = 0, bck = 0, lrck = 0, scki = 0, dout = 0, underrun = 0, in_ready = 1.
  - sh_l/sh_r = 0, hold_full = 0.
  - The first frame after reset outputs zeros. No underrun pulse at reset itself.
- Reset mid-frame:
  - All state returns to reset values at that clk edge.
  - A held sample is discarded, and in_ready = 1 on the next cycle.
  - The frame restarts at k = 0 after reset deasserts.

Test Plan:
- Clocking (BCK_DIV=4), hold reset 10 clk, then run ≥ 3 frames:
  - bck period 4 clk, scki period 2 clk.
  - lrck period 256 clk, low for 128 clk.
  - dout = 0 throughout frame 0.
  - underrun pulses exactly at the frame-0 → frame-1 boundary.
- Push left=24'hA5A5A5, right=24'h5A5A5A during frame 0:
  - in_ready drops the following clk and rises 1 clk after the frame-1 load.
  - Bits captured on bck rising edges: k = 1..24 → A5A5A5, k = 33..56 → 5A5A5A.
  - k = 0, 25–32 and 57–63 → 0.
  - No underrun at that boundary.
- Backpressure: push 24'h123456/24'hABCDEF, then immediately hold in_valid with 24'h7FFFFF/24'h800000:
  - Second sample is accepted only after the next frame load.
  - Frames carry the first sample, then the second. No loss, no duplication.
- Same-cycle accept and load: assert in_valid exactly on the k 63 → 0 wrap clk:
  - underrun pulses and that frame is all zeros.
  - The sample appears in the following frame.
- Reset mid-frame: assert reset at k = 40 with a sample held:
  - Next clk: bck, lrck, dout = 0, in_ready = 1.
  - The discarded sample is never transmitted.
  - The frame restarts at k = 0 after release.
